// File: rtl/pwm_capture.sv
// PWM capture: recovers duty (high time) of a PERIOD-cycle PWM frame from an async line.
// Optional `PWM_CAP_GLITCH_FILTER_EN adds a 3-sample majority filter after the synchronizer.
`timescale 1ns/1ps
module pwm_capture #(
    parameter int PERIOD = 256,
    parameter int CW     = 9
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          en,
    input  logic          pwm_in,
    output logic [CW-1:0] duty,
    output logic          duty_valid,
    output logic          period_err,
    output logic          locked
);

    typedef enum logic [1:0] {IDLE, SEEK, MEASURE} state_t;

    localparam logic [CW-1:0] FRAME = CW'(PERIOD);
    localparam logic [CW-1:0] SAT   = CW'(PERIOD + 1);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == SAT) ? v : v + 1'b1;
    endfunction

    state_t        state, state_next;
    logic          sync1, sync2, s, s_d, rise;
    logic [CW-1:0] pcnt, hcnt, run;

    logic          cnt_clear, frame_load, run_restart;
    logic          duty_load, valid_next, err_next, lock_set, lock_clr;
    logic [CW-1:0] duty_val;

    // NOTE: every clocked process uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            sync2 <= sync1;
        end
    end

`ifdef PWM_CAP_GLITCH_FILTER_EN
    logic [1:0] hist;
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) hist <= '0;
        else       hist <= {hist[0], sync2};
    end
    // Majority of the last three synced samples delays both edges by one cycle.
    assign s = (sync2 & hist[0]) | (sync2 & hist[1]) | (hist[0] & hist[1]);
`else
    assign s = sync2;
`endif

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) s_d <= 1'b0;
        else       s_d <= s;
    end

    assign rise = s & ~s_d;

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: all combinational outputs get a default first so no latch is inferred.
    always_comb begin
        state_next  = state;
        cnt_clear   = 1'b0;
        frame_load  = 1'b0;
        run_restart = 1'b0;
        duty_load   = 1'b0;
        duty_val    = '0;
        valid_next  = 1'b0;
        err_next    = 1'b0;
        lock_set    = 1'b0;
        lock_clr    = 1'b0;
        if (!en) begin
            state_next = IDLE;
            cnt_clear  = 1'b1;
            lock_clr   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    cnt_clear  = 1'b1;
                    state_next = SEEK;
                end
                SEEK, MEASURE: begin
                    // Priority: rise, then constant-level, then overflow.
                    if (rise) begin
                        frame_load = 1'b1;
                        state_next = MEASURE;
                        if (state == MEASURE) begin
                            if (pcnt == FRAME) begin
                                duty_load  = 1'b1;
                                duty_val   = hcnt;
                                valid_next = 1'b1;
                                lock_set   = 1'b1;
                            end else begin
                                err_next = 1'b1;
                                lock_clr = 1'b1;
                            end
                        end
                    end else if (run == FRAME) begin
                        duty_load   = 1'b1;
                        duty_val    = s ? FRAME : '0;
                        valid_next  = 1'b1;
                        lock_set    = 1'b1;
                        run_restart = 1'b1;
                        state_next  = SEEK;
                    end else if (state == MEASURE && pcnt == SAT) begin
                        err_next   = 1'b1;
                        lock_clr   = 1'b1;
                        state_next = SEEK;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            pcnt <= '0;
            hcnt <= '0;
            run  <= '0;
        end else if (cnt_clear) begin
            pcnt <= '0;
            hcnt <= '0;
            run  <= '0;
        end else begin
            pcnt <= frame_load ? CW'(1) : sat_inc(pcnt);
            hcnt <= frame_load ? CW'(1) : (s ? sat_inc(hcnt) : hcnt);
            run  <= (run_restart || s != s_d) ? CW'(1) : sat_inc(run);
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            duty       <= '0;
            duty_valid <= 1'b0;
            period_err <= 1'b0;
            locked     <= 1'b0;
        end else begin
            if (duty_load) duty <= duty_val;
            duty_valid <= valid_next;
            period_err <= err_next;
            if (lock_clr)      locked <= 1'b0;
            else if (lock_set) locked <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: good frames, constant line, bad period, line stop,
// async reset, glitch (filter-aware) and enable drop.
`timescale 1ns/1ps
module tb_pwm_capture;

    localparam int PERIOD = 256;
    localparam int CW     = 9;
`ifdef PWM_CAP_GLITCH_FILTER_EN
    localparam int X = 1;
`else
    localparam int X = 0;
`endif

    logic          clk = 1'b0;
    logic          arst = 1'b0;
    logic          en = 1'b0;
    logic          pwm_in = 1'b0;
    logic [CW-1:0] duty;
    logic          duty_valid, period_err, locked;

    int vectors = 0, miscompares = 0;
    int cyc = 0, n_valid, n_err, gap_bad, both_seen = 0;
    int last_valid, first_valid, first_err;

    pwm_capture #(.PERIOD(PERIOD), .CW(CW)) dut (
        .clk(clk), .arst(arst), .en(en), .pwm_in(pwm_in),
        .duty(duty), .duty_valid(duty_valid), .period_err(period_err), .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic clear_stats();
        n_valid = 0; n_err = 0; gap_bad = 0;
        last_valid = -1; first_valid = -1; first_err = -1;
    endtask

    // One clock with pwm_in at the given level; outputs sampled 1ns after the edge.
    task automatic step(input logic level);
        pwm_in = level;
        @(posedge clk);
        #1;
        cyc++;
        if (duty_valid) begin
            n_valid++;
            if (last_valid >= 0 && cyc - last_valid != PERIOD) gap_bad++;
            last_valid = cyc;
            if (first_valid < 0) first_valid = cyc;
        end
        if (period_err) begin
            n_err++;
            if (first_err < 0) first_err = cyc;
        end
        if (duty_valid && period_err) both_seen++;
    endtask

    task automatic frame(input int high, input int total);
        for (int i = 0; i < total; i++) step(i < high);
    endtask

    task automatic restart();
        en = 1'b0;
        step(1'b0); step(1'b0);
        en = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0);
        clear_stats();
    endtask

    task automatic test_reset();
        arst = 1'b0;
        step(1'b0); step(1'b0);
        vectors++; if (duty !== 9'd0) begin miscompares++; $display("FAIL reset_duty: got %0d want 0", duty); end
        vectors++; if (duty_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", duty_valid); end
        vectors++; if (period_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", period_err); end
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked: got %b want 0", locked); end
        arst = 1'b1;
        step(1'b0);
    endtask

    task automatic test_duty64();
        int r2;
        restart();
        frame(64, PERIOD);
        r2 = cyc;
        for (int f = 0; f < 5; f++) frame(64, PERIOD);
        vectors++; if (n_valid !== 5) begin miscompares++; $display("FAIL d64_count: got %0d want 5", n_valid); end
        vectors++; if (n_err !== 0) begin miscompares++; $display("FAIL d64_err: got %0d want 0", n_err); end
        vectors++; if (duty !== 9'd64) begin miscompares++; $display("FAIL d64_duty: got %0d want 64", duty); end
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL d64_locked: got %b want 1", locked); end
        vectors++; if (gap_bad !== 0) begin miscompares++; $display("FAIL d64_gap: got %0d bad gaps want 0", gap_bad); end
        vectors++; if (first_valid - r2 !== 3 + X) begin miscompares++; $display("FAIL d64_latency: got %0d want %0d", first_valid - r2, 3 + X); end
    endtask

    task automatic test_constant();
        restart();
        for (int i = 0; i < 1000; i++) step(1'b0);
        vectors++; if (n_valid !== 3) begin miscompares++; $display("FAIL low_count: got %0d want 3", n_valid); end
        vectors++; if (duty !== 9'd0) begin miscompares++; $display("FAIL low_duty: got %0d want 0", duty); end
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL low_locked: got %b want 1", locked); end
        vectors++; if (gap_bad !== 0 || n_err !== 0) begin miscompares++; $display("FAIL low_gap_err: got gaps %0d errs %0d want 0 0", gap_bad, n_err); end
        clear_stats();
        for (int i = 0; i < 1000; i++) step(1'b1);
        vectors++; if (n_valid !== 3) begin miscompares++; $display("FAIL high_count: got %0d want 3", n_valid); end
        vectors++; if (duty !== 9'd256) begin miscompares++; $display("FAIL high_duty: got %0d want 256", duty); end
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL high_locked: got %b want 1", locked); end
        vectors++; if (gap_bad !== 0 || n_err !== 0) begin miscompares++; $display("FAIL high_gap_err: got gaps %0d errs %0d want 0 0", gap_bad, n_err); end
    endtask

    task automatic test_bad_period();
        clear_stats();
        for (int i = 0; i < 100; i++) step(1'b0);
        for (int f = 0; f < 5; f++) frame(100, 200);
        vectors++; if (n_err !== 4) begin miscompares++; $display("FAIL bad_err: got %0d want 4", n_err); end
        vectors++; if (n_valid !== 0) begin miscompares++; $display("FAIL bad_valid: got %0d want 0", n_valid); end
        vectors++; if (duty !== 9'd256) begin miscompares++; $display("FAIL bad_duty: got %0d want 256", duty); end
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL bad_locked: got %b want 0", locked); end
    endtask

    task automatic test_stop();
        int r, f;
        restart();
        for (int k = 0; k < 4; k++) frame(64, PERIOD);
        vectors++; if (n_valid !== 3 || duty !== 9'd64) begin miscompares++; $display("FAIL stop_pre: got %0d valids duty %0d want 3 64", n_valid, duty); end
        r = cyc;
        for (int i = 0; i < 50; i++) step(1'b1);
        f = cyc;
        for (int i = 0; i < 400; i++) step(1'b0);
        vectors++; if (n_err !== 1) begin miscompares++; $display("FAIL stop_err: got %0d want 1", n_err); end
        vectors++; if (first_err - r !== 260 + X) begin miscompares++; $display("FAIL stop_err_time: got %0d want %0d", first_err - r, 260 + X); end
        vectors++; if (n_valid !== 5) begin miscompares++; $display("FAIL stop_valid: got %0d want 5", n_valid); end
        vectors++; if (last_valid - f !== 259 + X) begin miscompares++; $display("FAIL stop_zero_time: got %0d want %0d", last_valid - f, 259 + X); end
        vectors++; if (duty !== 9'd0 || locked !== 1'b1) begin miscompares++; $display("FAIL stop_final: got duty %0d locked %b want 0 1", duty, locked); end
    endtask

    task automatic test_async_reset();
        int rb;
        restart();
        frame(64, PERIOD); frame(64, PERIOD);
        for (int i = 0; i < 30; i++) step(1'b1);
        vectors++; if (locked !== 1'b1 || duty !== 9'd64) begin miscompares++; $display("FAIL ar_pre: got locked %b duty %0d want 1 64", locked, duty); end
        arst = 1'b0;
        #1;
        vectors++; if (duty !== 9'd0) begin miscompares++; $display("FAIL ar_duty: got %0d want 0", duty); end
        vectors++; if (locked !== 1'b0 || duty_valid !== 1'b0 || period_err !== 1'b0) begin miscompares++; $display("FAIL ar_flags: got %b%b%b want 000", locked, duty_valid, period_err); end
        step(1'b0); step(1'b0); step(1'b0);
        arst = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0);
        clear_stats();
        frame(64, PERIOD);
        rb = cyc;
        frame(64, PERIOD); frame(64, PERIOD);
        vectors++; if (n_valid !== 2 || n_err !== 0) begin miscompares++; $display("FAIL ar_count: got %0d valids %0d errs want 2 0", n_valid, n_err); end
        vectors++; if (first_valid - rb !== 3 + X) begin miscompares++; $display("FAIL ar_first: got %0d want %0d", first_valid - rb, 3 + X); end
        vectors++; if (duty !== 9'd64 || locked !== 1'b1) begin miscompares++; $display("FAIL ar_final: got duty %0d locked %b want 64 1", duty, locked); end
    endtask

    task automatic test_glitch();
        restart();
        frame(64, PERIOD); frame(64, PERIOD);
        frame(64, 124);
        step(1'b1);
        frame(0, 131);
        vectors++; if (n_err !== 1 - X) begin miscompares++; $display("FAIL gl_err: got %0d want %0d", n_err, 1 - X); end
        vectors++; if (locked !== 1'(X)) begin miscompares++; $display("FAIL gl_locked: got %b want %0d", locked, X); end
        vectors++; if (n_valid !== 2 || duty !== 9'd64) begin miscompares++; $display("FAIL gl_valid: got %0d duty %0d want 2 64", n_valid, duty); end
        frame(64, PERIOD); frame(64, PERIOD);
        vectors++; if (n_err !== 2 - 2 * X) begin miscompares++; $display("FAIL gl_err_end: got %0d want %0d", n_err, 2 - 2 * X); end
        vectors++; if (n_valid !== 3 + X || duty !== 9'd64 || locked !== 1'b1) begin miscompares++; $display("FAIL gl_end: got %0d duty %0d locked %b want %0d 64 1", n_valid, duty, locked, 3 + X); end
    endtask

    task automatic test_en_drop();
        clear_stats();
        for (int i = 0; i < 40; i++) step(i < 20);
        en = 1'b0;
        step(1'b0);
        vectors++; if (locked !== 1'b0 || duty_valid !== 1'b0 || period_err !== 1'b0) begin miscompares++; $display("FAIL en_drop: got %b%b%b want 000", locked, duty_valid, period_err); end
        vectors++; if (duty !== 9'd64) begin miscompares++; $display("FAIL en_duty_hold: got %0d want 64", duty); end
        vectors++; if (both_seen !== 0) begin miscompares++; $display("FAIL strobe_overlap: got %0d want 0", both_seen); end
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_duty64();
        test_constant();
        test_bad_period();
        test_stop();
        test_async_reset();
        test_glitch();
        test_en_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Receive-side counterpart of the fan-speed PWM generator in the cool/heat system. Samples an asynchronous PWM line, measures high time and period against a fixed frame length, and returns the recovered duty value as a number directly comparable to the generator's `speed` input. It sits on the fan/heater feedback path so the controller can confirm the commanded speed is present on the wire.

## Interface
Parameters:
- `PERIOD`, 256: expected frame length in `clk` cycles.
- `CW`, 9: counter/duty width; must hold `PERIOD + 1`.

Ports:
- `clk`  in  1  clock.
- `arst`  in  1  reset, asynchronous, active-low.
- `en`  in  1  capture enable; low forces IDLE.
- `pwm_in`  in  1  asynchronous PWM line.
- `duty`  out  CW  last recovered high-time, range 0..PERIOD.
- `duty_valid`  out  1  one-cycle strobe when `duty` is updated.
- `period_err`  out  1  one-cycle strobe on a frame that is not exactly `PERIOD` long.
- `locked`  out  1  high after a good frame; low after error, IDLE or reset.

## Operation
- Input conditioning: 2-flop synchronizer on `pwm_in` produces `s`. The previous-cycle copy `s_d` gives rise detection `rise = s & ~s_d`.
- Counters, all `CW` bits wide and saturating at `PERIOD + 1`:
  - `pcnt` counts cycles since the last rise.
  - `hcnt` counts cycles with `s = 1` since the last rise.
  - `run` counts consecutive cycles at the same `s` level.
- States:
  - IDLE: counters cleared, outputs hold. Go to SEEK when `en = 1`.
  - SEEK: waiting for the first rise. On `rise`, load `pcnt = 1`, `hcnt = 1`, go to MEASURE.
  - MEASURE, on `rise`:
    - If `pcnt == PERIOD`: `duty <= hcnt`, pulse `duty_valid`, set `locked`.
    - Otherwise: pulse `period_err`, clear `locked`, leave `duty` unchanged.
    - In both cases reload `pcnt = 1`, `hcnt = 1` and stay in MEASURE.
  - MEASURE, on `pcnt` reaching `PERIOD + 1` without a rise: pulse `period_err`, clear `locked`, go to SEEK.
- Constant-level rule (SEEK or MEASURE): when `run` reaches `PERIOD`:
  - `duty <= 0` if `s = 0`, `duty <= PERIOD` if `s = 1`.
  - Pulse `duty_valid`, set `locked`, restart `run` at 1, go to SEEK.
  - Repeats every `PERIOD` cycles while the line stays constant.
- Precedence when events fall in the same cycle:
  - Constant-level rule beats the `pcnt` overflow error.
  - `rise` beats both.
- `en` falling in any state: next cycle is IDLE, `locked <= 0`, no strobe. A partial frame is discarded.

## Timing
- Reset values: `duty = 0`, `duty_valid = 0`, `period_err = 0`, `locked = 0`, state IDLE, synchronizer flops 0, all counters 0.
- Reset is asynchronous and may hit mid-frame; after release the block restarts from IDLE/SEEK and ignores the partial frame.
- Latency: `pwm_in` rise to internal `rise` is 2 cycles. `duty` / `duty_valid` / `period_err` are registered on the `rise` cycle, so they are visible 3 cycles after the `pwm_in` edge.
- Steady state with a valid generator: exactly one `duty_valid` every `PERIOD` cycles. The first one comes on the second rise after leaving IDLE.
- `duty_valid` and `period_err` are never high in the same cycle. Each is exactly one cycle wide.
- All outputs are registered; there are no combinational paths from `pwm_in`.

## Configuration
- `PWM_CAP_GLITCH_FILTER_EN` defined:
  - A 3-sample majority filter follows the synchronizer; `s` is the majority of the last 3 synced samples.
  - Single-cycle glitches are rejected.
  - Latency grows to 4 cycles, and high time shifts by zero net (both edges are delayed equally).
- `PWM_CAP_GLITCH_FILTER_EN` undefined: `s` is the raw synchronizer output, latency 3 cycles, and a 1-cycle glitch produces a `rise` (normally a `period_err`).

## Test plan
- Duty 64, period 256, `en = 1`: from the second rise, `duty = 64` with `duty_valid` every 256 cycles, `locked = 1`, `period_err` never pulses.
- Line held low 1000 cycles: `duty = 0` strobed every 256 cycles, `locked = 1`. Held high: `duty = 256` every 256 cycles.
- Duty 100, period 200: `period_err` pulse at each rise, `locked = 0`, `duty` unchanged from its previous value.
- Duty 64 frames, then the line stops high for 50 cycles and low afterward:
  - One `period_err` when `pcnt` hits 257.
  - Then `duty = 0` strobes begin 256 cycles after the falling edge.
- Mid-frame `arst` low for 3 cycles: all outputs return to reset values immediately. After release, the first `duty_valid` comes on the second rise, value 64.
- Single 1-cycle glitch inside a duty-64 frame:
  - Without the macro: `period_err`, `locked` drops.
  - With `PWM_CAP_GLITCH_FILTER_EN`: no error, `duty = 64` maintained.
